// File: rtl/note_sequencer.sv
// Column-stepping sequencer for an 8x8 note grid. It sweeps the columns at a
// fixed beat rate and offers each column's active rows as a chord downstream.
module note_sequencer #(
  parameter int unsigned BEAT_CYCLES = 5000000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [63:0] iNote,
  input  logic        iSave,
  input  logic        iStart,
  input  logic        iStop,
  input  logic        iReady,
  output logic [7:0]  oChord,
  output logic [7:0]  oAttack,
  output logic [2:0]  oColumn,
  output logic        oValid,
  output logic        oOverrun,
  output logic        oPlaying
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [25:0] BEAT_LAST = 26'(BEAT_CYCLES - 1);

  state_t      state_reg;
  logic [63:0] pend_reg;
  logic [63:0] snap_reg;
  logic [25:0] tmr_reg;
  logic [7:0]  chord_reg;
  logic [7:0]  attack_reg;
  logic [2:0]  column_reg;
  logic        valid_reg;
  logic        overrun_reg;

  logic        beat;
  logic        wrap;
  logic [2:0]  column_inc;
  logic [7:0]  chord_start;
  logic [7:0]  chord_beat;

  assign beat       = (state_reg == RUN) && (tmr_reg == BEAT_LAST);
  assign wrap       = (column_reg == 3'd7);
  assign column_inc = column_reg + 3'd1;

  // A new sweep (start or 7->0 wrap) reads column 0 straight from the pending
  // grid, since that is exactly what gets copied into the snapshot on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row
      logic [7:0] snap_row;
      assign snap_row        = snap_reg[gi*8 +: 8];
      assign chord_start[gi] = pend_reg[gi*8];
      assign chord_beat[gi]  = wrap ? pend_reg[gi*8] : snap_row[column_inc];
    end
  endgenerate

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg   <= IDLE;
      pend_reg    <= '0;
      snap_reg    <= '0;
      tmr_reg     <= '0;
      chord_reg   <= '0;
      attack_reg  <= '0;
      column_reg  <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (iSave)
        pend_reg <= iNote;
      overrun_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (iStart && !iStop) begin
            state_reg  <= RUN;
            tmr_reg    <= '0;
            snap_reg   <= pend_reg;
            column_reg <= 3'd0;
            chord_reg  <= chord_start;
            attack_reg <= chord_start;
            valid_reg  <= |chord_start;
          end
        end
        RUN: begin
          if (iStop) begin
            state_reg  <= IDLE;
            tmr_reg    <= '0;
            chord_reg  <= '0;
            attack_reg <= '0;
            column_reg <= 3'd0;
            valid_reg  <= 1'b0;
          end else if (beat) begin
            tmr_reg     <= '0;
            column_reg  <= column_inc;
            if (wrap)
              snap_reg <= pend_reg;
            chord_reg   <= chord_beat;
            attack_reg  <= chord_beat & ~chord_reg;
            valid_reg   <= |chord_beat;
            // An acceptance in the beat cycle itself still counts as taken.
            overrun_reg <= valid_reg && !iReady;
          end else begin
            tmr_reg <= tmr_reg + 26'd1;
            if (valid_reg && iReady)
              valid_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign oChord   = chord_reg;
  assign oAttack  = attack_reg;
  assign oColumn  = column_reg;
  assign oValid   = valid_reg;
  assign oOverrun = overrun_reg;
  assign oPlaying = (state_reg == RUN);

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: expected presentations are queued as
// stimulus is driven and compared when the sequencer presents a chord.
module tb_note_sequencer;

  localparam int BEAT = 4;

  logic        iCLK;
  logic        iRST_N;
  logic [63:0] iNote;
  logic        iSave;
  logic        iStart;
  logic        iStop;
  logic        iReady;
  logic [7:0]  oChord;
  logic [7:0]  oAttack;
  logic [2:0]  oColumn;
  logic        oValid;
  logic        oOverrun;
  logic        oPlaying;

  note_sequencer #(.BEAT_CYCLES(BEAT)) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iNote   (iNote),
    .iSave   (iSave),
    .iStart  (iStart),
    .iStop   (iStop),
    .iReady  (iReady),
    .oChord  (oChord),
    .oAttack (oAttack),
    .oColumn (oColumn),
    .oValid  (oValid),
    .oOverrun(oOverrun),
    .oPlaying(oPlaying)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [2:0] col;
    logic [7:0] chord;
    logic [7:0] attack;
    logic       valid;
    logic       ovr;
  } pres_t;

  pres_t       sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] m_pend;
  logic [63:0] m_snap;
  logic [2:0]  m_col;
  logic [7:0]  m_prev;

  localparam logic [63:0] G34  = 64'h0000_0000_0008_0C04;
  localparam logic [63:0] GOVR = 64'h0000_0000_0000_0201;
  localparam logic [63:0] GA   = 64'h8142_2418_1824_4281;
  localparam logic [63:0] GB   = 64'h0F0F_F0F0_3C3C_C3C3;
  localparam logic [63:0] GC   = 64'hAA55_AA55_0FF0_0FF0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] chord_of(input logic [63:0] g, input logic [2:0] c);
    logic [7:0] f;
    for (int r = 0; r < 8; r++) f[r] = g[r*8 + int'(c)];
    return f;
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic push_pres(input bit is_start, input bit ovr);
    pres_t e;
    if (is_start) begin
      m_col  = 3'd0;
      m_snap = m_pend;
      m_prev = 8'h00;
    end else begin
      m_col = m_col + 3'd1;
      if (m_col == 3'd0) m_snap = m_pend;
    end
    e.col    = m_col;
    e.chord  = chord_of(m_snap, m_col);
    e.attack = e.chord & ~m_prev;
    e.valid  = (e.chord != 8'h00);
    e.ovr    = ovr;
    m_prev   = e.chord;
    sb.push_back(e);
  endtask

  task automatic present_check(input string tag);
    pres_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    $display("[TB] %s col=%0d chord=%02h attack=%02h valid=%0b ovr=%0b", tag,
             oColumn, oChord, oAttack, oValid, oOverrun);
    check({tag, "_col"},     32'(oColumn),  32'(e.col));
    check({tag, "_chord"},   32'(oChord),   32'(e.chord));
    check({tag, "_attack"},  32'(oAttack),  32'(e.attack));
    check({tag, "_valid"},   32'(oValid),   32'(e.valid));
    check({tag, "_overrun"}, 32'(oOverrun), 32'(e.ovr));
    check({tag, "_playing"}, 32'(oPlaying), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    $display("[TB] %s idle check chord=%02h col=%0d valid=%0b playing=%0b", tag,
             oChord, oColumn, oValid, oPlaying);
    check({tag, "_chord"},   32'(oChord),   32'd0);
    check({tag, "_attack"},  32'(oAttack),  32'd0);
    check({tag, "_col"},     32'(oColumn),  32'd0);
    check({tag, "_valid"},   32'(oValid),   32'd0);
    check({tag, "_overrun"}, 32'(oOverrun), 32'd0);
    check({tag, "_playing"}, 32'(oPlaying), 32'd0);
  endtask

  task automatic save_grid(input logic [63:0] g);
    iNote = g;
    iSave = 1'b1;
    tick();
    iSave = 1'b0;
    m_pend = g;
  endtask

  task automatic start_play(input int rdy);
    iReady = (rdy == 1);
    iStart = 1'b1;
    push_pres(1'b1, 1'b0);
    tick();
    iStart = 1'b0;
    present_check("start");
  endtask

  task automatic stop_play(input string tag);
    iStop = 1'b1;
    tick();
    iStop = 1'b0;
    check_idle(tag);
  endtask

  // rdy: 0 = iReady held low, 1 = held high, 2 = high only in the beat cycle.
  // save_mode: 0 = none, 1 = save in first cycle of interval, 2 = save in beat cycle.
  task automatic next_beat(input int rdy, input int save_mode, input logic [63:0] g);
    bit ovr;
    for (int i = 0; i < BEAT; i++) begin
      iReady = (rdy == 1) || (rdy == 2 && i == BEAT - 1);
      iSave  = (save_mode == 1 && i == 0) || (save_mode == 2 && i == BEAT - 1);
      iNote  = g;
      if (i == BEAT - 1) begin
        ovr = (m_prev != 8'h00) && (rdy == 0);
        push_pres(1'b0, ovr);
      end
      tick();
      if (save_mode == 1 && i == 0) m_pend = g;
      if (i == 0) begin
        check("hs_valid", 32'(oValid), 32'((m_prev != 8'h00) && (rdy != 1)));
        check("ovr_clear", 32'(oOverrun), 32'd0);
      end
    end
    iSave = 1'b0;
    present_check("beat");
    if (save_mode == 2) m_pend = g;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST_N = 1'b0; iNote = '0; iSave = 1'b0; iStart = 1'b0; iStop = 1'b0; iReady = 1'b0;
    m_pend = '0; m_snap = '0; m_col = '0; m_prev = '0;
    repeat (3) @(posedge iCLK);
    #1;
    check_idle("reset");
    iRST_N = 1'b1;
    tick();
    check_idle("reset_rel");

    // Simultaneous start and stop in IDLE: stop wins
    iStart = 1'b1; iStop = 1'b1;
    tick();
    iStart = 1'b0; iStop = 1'b0;
    check_idle("start_stop");
    tick();
    check_idle("start_stop_after");

    // Single-note grid, full sweep plus wrap
    save_grid(64'h0000_0000_0000_0081);
    start_play(1);
    check("first_chord", 32'(oChord), 32'h01);
    for (int b = 0; b < 8; b++) next_beat(1, 0, '0);
    stop_play("stop_sweep");

    // Column 2 rows {0,1}, column 3 rows {1,2}
    save_grid(G34);
    start_play(1);
    for (int b = 0; b < 3; b++) next_beat(1, 0, '0);
    check("c3_chord", 32'(oChord), 32'h06);
    check("c3_attack", 32'(oAttack), 32'h04);
    iStart = 1'b1;
    next_beat(1, 0, '0);
    iStart = 1'b0;
    stop_play("stop_c34");

    // Overrun when nothing is accepted, none when accepted on the beat cycle
    save_grid(GOVR);
    start_play(0);
    next_beat(0, 0, '0);
    check("ovr_pulse", 32'(oOverrun), 32'd1);
    tick();
    check("ovr_one_cycle", 32'(oOverrun), 32'd0);
    stop_play("stop_ovr");
    start_play(0);
    next_beat(2, 0, '0);
    check("ovr_none", 32'(oOverrun), 32'd0);
    stop_play("stop_ovr2");

    // Grid change mid-sweep takes effect at the next wrap; beat-cycle save waits a sweep
    save_grid(GA);
    start_play(1);
    for (int b = 0; b < 3; b++) next_beat(1, 0, '0);
    next_beat(1, 1, GB);
    for (int b = 0; b < 3; b++) next_beat(1, 0, '0);
    next_beat(1, 0, '0);
    check("wrap_new_grid", 32'(oChord), 32'(chord_of(GB, 3'd0)));
    for (int b = 0; b < 7; b++) next_beat(1, 0, '0);
    next_beat(1, 2, GC);
    check("wrap_same_cycle_save", 32'(oChord), 32'(chord_of(GB, 3'd0)));
    for (int b = 0; b < 8; b++) next_beat(1, 0, '0);
    check("wrap_late_grid", 32'(oChord), 32'(chord_of(GC, 3'd0)));
    stop_play("stop_wrap");

    // Asynchronous reset while a chord is on offer
    save_grid(GOVR);
    start_play(0);
    tick();
    check("pre_rst_valid", 32'(oValid), 32'd1);
    #1 iRST_N = 1'b0;
    #1;
    check_idle("async_rst");
    sb.delete();
    m_pend = '0;
    repeat (2) tick();
    iRST_N = 1'b1;
    tick();
    check_idle("post_rst");
    start_play(1);
    next_beat(1, 0, '0);
    stop_play("stop_post_rst");
    save_grid(GOVR);
    start_play(1);
    check("resaved_chord", 32'(oChord), 32'h01);
    stop_play("stop_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter BEAT_CYCLES, default 5000000, clock cycles per column step (legal range 2..2^26-1).
REQ-002 SHALL have port iCLK  input  1  single clock for all logic.
REQ-003 SHALL have port iRST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iNote  input  64  8x8 detection grid, bit r*8+c = row r (top=0), column c (left=0).
REQ-005 SHALL have port iSave  input  1  grid-valid strobe; iNote is captured in any cycle this is 1.
REQ-006 SHALL have port iStart  input  1  start-playback request, level-sampled.
REQ-007 SHALL have port iStop  input  1  stop-playback request, level-sampled.
REQ-008 SHALL have port iReady  input  1  downstream synth accepts chord.
REQ-009 SHALL have port oChord  output  8  active rows of the current column, bit r = grid row r.
REQ-010 SHALL have port oAttack  output  8  rows newly active versus the previous presented chord.
REQ-011 SHALL have port oColumn  output  3  column index currently presented.
REQ-012 SHALL have port oValid  output  1  chord offered to downstream.
REQ-013 SHALL have port oOverrun  output  1  one-cycle pulse: offered chord replaced before acceptance.
REQ-014 SHALL have port oPlaying  output  1  1 while in RUN state.

Function
REQ-015 SHALL hold pending grid pend[63:0]; pend <= iNote on every cycle with iSave=1, in any state.
REQ-016 SHALL implement FSM with states IDLE and RUN; IDLE -> RUN on iStart=1 and iStop=0; RUN -> IDLE on iStop=1; iStop wins over iStart in the same cycle; iStart in RUN ignored.
REQ-017 SHALL run beat timer tmr only in RUN: increments each cycle, wraps 0 at BEAT_CYCLES-1 (beat event); held at 0 in IDLE.
REQ-018 SHALL present a chord ("presentation") on the cycle after IDLE->RUN (column 0) and on the cycle after every beat event.
REQ-019 SHALL on each beat advance oColumn by 1 modulo 8 (7 wraps to 0).
REQ-020 SHALL load the sweep snapshot snap <= pend at IDLE->RUN and at every 7->0 wrap; a same-cycle iSave value is not in that snapshot and appears next sweep.
REQ-021 SHALL present oChord[r] = snapshot[r*8+oColumn] with the snapshot for that sweep, including the one newly loaded at that wrap.
REQ-022 SHALL present oAttack = new oChord AND NOT previous oChord; previous chord treated as 0 for the first presentation after start.
REQ-023 SHALL hold oChord, oAttack, oColumn stable between presentations.
REQ-024 SHALL set oValid=1 at presentation if new chord nonzero, else oValid=0.
REQ-025 SHALL clear oValid the cycle after any cycle with oValid=1 and iReady=1 (handshake), unless a presentation occurs then.
REQ-026 SHALL pulse oOverrun=1 for exactly one cycle at a presentation when the prior chord has oValid=1 and iReady=0 in the beat-event cycle; iReady=1 in that cycle counts as accepted, no overrun.
REQ-027 SHALL on RUN -> IDLE, next cycle: oValid=0, oChord=0, oAttack=0, oColumn=0, tmr=0, oPlaying=0, oOverrun=0; pend retained.
REQ-028 SHALL use latency 1 cycle from beat/start event to updated outputs; no combinational path from inputs to outputs.

Reset
REQ-029 SHALL on iRST_N=0 asynchronously force IDLE, pend=0, snap=0, tmr=0, oChord=0, oAttack=0, oColumn=0, oValid=0, oOverrun=0, oPlaying=0.
REQ-030 SHALL on reset asserted mid-RUN discard the offered chord without a handshake; after release wait in IDLE for iStart.

Verification (BEAT_CYCLES=4)
REQ-031 SHALL cover: iNote=64'h0000_0000_0000_0081 with iSave=1, then iStart pulse -> next cycle oColumn=0, oChord=8'h01, oAttack=8'h01, oValid=1; 4 cycles later oColumn=1, oChord=0, oValid=0.
REQ-032 SHALL cover: iReady held 0, nonzero chords in columns 0 and 1 -> oOverrun=1 for one cycle at column-1 presentation; repeated with iReady=1 in the beat cycle -> oOverrun stays 0.
REQ-033 SHALL cover: new iNote saved at column 3 -> columns 4..7 still from old grid; at 7->0 wrap oChord reflects new grid.
REQ-034 SHALL cover: grid column 2 rows {0,1}, column 3 rows {1,2} -> column-3 presentation oChord=8'h06, oAttack=8'h04.
REQ-035 SHALL cover: iStart=1 and iStop=1 same cycle in IDLE -> stays IDLE, oPlaying=0; iStop in RUN -> all outputs 0 next cycle.
REQ-036 SHALL cover: iRST_N low mid-beat with oValid=1 -> outputs 0 immediately (asynchronously); after release, iStart -> oColumn=0, oChord from pend (pend cleared, so 0 unless re-saved).
